// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle control FSM for the LEGv8 core: fetch/decode/execute/memory/writeback sequencing.
// Optional macro LEGV8_ILLEGAL_TRAP_EN: illegal opcodes halt the FSM instead of retiring as NOPs.
module legv8_multicycle_ctrl #(
    parameter int BRANCHOP_W = 3,
    parameter int ALUOP_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           opcode,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  iord,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_src_inc,
    output logic [BRANCHOP_W-1:0] branch_op,
    output logic                  setflags,
    output logic                  alu_src_imm,
    output logic [ALUOP_W-1:0]    alu_op,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  link,
    output logic                  retire,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_RTYPE, C_ADDI, C_LDUR, C_STUR,
        C_B, C_BL, C_CBZ, C_CBNZ, C_BCOND, C_BR
    } iclass_t;

    localparam logic [BRANCHOP_W-1:0] BOP_NONE  = BRANCHOP_W'(0);
    localparam logic [BRANCHOP_W-1:0] BOP_B     = BRANCHOP_W'(1);
    localparam logic [BRANCHOP_W-1:0] BOP_BR    = BRANCHOP_W'(2);
    localparam logic [BRANCHOP_W-1:0] BOP_BL    = BRANCHOP_W'(3);
    localparam logic [BRANCHOP_W-1:0] BOP_CBZ   = BRANCHOP_W'(4);
    localparam logic [BRANCHOP_W-1:0] BOP_CBNZ  = BRANCHOP_W'(5);
    localparam logic [BRANCHOP_W-1:0] BOP_BCOND = BRANCHOP_W'(6);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(3);

    state_t  state_q, state_d;
    iclass_t class_q, class_d;
    logic    sflag_q, sflag_d;
    logic    illegal_q, illegal_d;
    iclass_t dec_class;
    logic    dec_sflag;

    // Opcode classification; dec_sflag marks the flag-setting R-type forms.
    always_comb begin
        dec_class = C_ILL;
        dec_sflag = 1'b0;
        casez (opcode)
            11'b10001011000,
            11'b11001011000: dec_class = C_RTYPE;
            11'b10101011000,
            11'b11101011000: begin
                dec_class = C_RTYPE;
                dec_sflag = 1'b1;
            end
            11'b1001000100?: dec_class = C_ADDI;
            11'b11111000010: dec_class = C_LDUR;
            11'b11111000000: dec_class = C_STUR;
            11'b000101?????: dec_class = C_B;
            11'b100101?????: dec_class = C_BL;
            11'b10110100???: dec_class = C_CBZ;
            11'b10110101???: dec_class = C_CBNZ;
            11'b01010100???: dec_class = C_BCOND;
            11'b11010110000: dec_class = C_BR;
            default:         dec_class = C_ILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            class_q   <= C_ILL;
            sflag_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            sflag_q   <= sflag_d;
            illegal_q <= illegal_d;
        end
    end

    // The IR is valid during DECODE, so the class is latched there for EXEC onward.
    assign class_d = (state_q == S_DECODE) ? dec_class : class_q;
    assign sflag_d = (state_q == S_DECODE) ? dec_sflag : sflag_q;
    assign illegal = illegal_q;

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src_inc  = 1'b0;
        branch_op   = BOP_NONE;
        setflags    = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        link        = 1'b0;
        retire      = 1'b0;
        // Strobes are masked while reset is held so nothing leaks during an abort.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        pc_src_inc = 1'b1;
                        state_d    = S_DECODE;
                    end
                end
                S_DECODE: state_d = S_EXEC;
                S_EXEC: begin
                    case (class_q)
                        C_RTYPE: begin
                            alu_op   = ALU_RTYPE;
                            setflags = sflag_q;
                            state_d  = S_WB;
                        end
                        C_ADDI: begin
                            alu_src_imm = 1'b1;
                            state_d     = S_WB;
                        end
                        C_LDUR, C_STUR: begin
                            alu_src_imm = 1'b1;
                            state_d     = S_MEM;
                        end
                        C_B, C_BR, C_CBZ, C_CBNZ, C_BCOND: begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                            case (class_q)
                                C_B:     branch_op = BOP_B;
                                C_BR:    branch_op = BOP_BR;
                                C_CBZ:   branch_op = BOP_CBZ;
                                C_CBNZ:  branch_op = BOP_CBNZ;
                                default: branch_op = BOP_BCOND;
                            endcase
                        end
                        C_BL: begin
                            branch_op = BOP_BL;
                            pc_write  = 1'b1;
                            state_d   = S_WB;
                        end
                        default: begin
`ifdef LEGV8_ILLEGAL_TRAP_EN
                            illegal_d = 1'b1;
                            state_d   = S_HALT;
`else
                            retire  = 1'b1;
                            state_d = S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_write = (class_q == C_STUR);
                    if (mem_ready) begin
                        if (class_q == C_STUR) begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (class_q == C_LDUR);
                    link       = (class_q == C_BL);
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
                default: state_d = S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Cycle-by-cycle scoreboard bench for legv8_multicycle_ctrl: expected strobes queued per cycle, popped on sample.
module tb_legv8_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src_inc;
        logic [2:0] branch_op;
        logic       setflags;
        logic       alu_src_imm;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       link;
        logic       retire;
        logic       illegal;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, iord, ir_write, pc_write, pc_src_inc;
    logic [2:0]  branch_op;
    logic        setflags, alu_src_imm;
    logic [1:0]  alu_op;
    logic        reg_write, mem_to_reg, link, retire, illegal;
    outs_t       got;

    int    n_checks = 0;
    int    n_fail   = 0;
    logic  ill_exp  = 1'b0;
    outs_t exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    legv8_multicycle_ctrl #(.BRANCHOP_W(3), .ALUOP_W(2)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src_inc(pc_src_inc), .branch_op(branch_op),
        .setflags(setflags), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .link(link),
        .retire(retire), .illegal(illegal)
    );

    assign got = '{mem_req, mem_write, iord, ir_write, pc_write, pc_src_inc, branch_op,
                   setflags, alu_src_imm, alu_op, reg_write, mem_to_reg, link, retire, illegal};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s got=%05h expected=%05h", tag, obs, req);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, queue the expectation, sample 2ns later.
    task automatic cycle(input string tag, input logic rst, input logic rdy, input outs_t e);
        outs_t pe;
        string pt;
        reset     = rst;
        mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        pe = exp_q.pop_front();
        pt = tag_q.pop_front();
        $display("txn %-14s opc=%b rst=%b rdy=%b out=%05h", pt, opcode, rst, rdy, 32'(got));
        check(pt, 32'(got), 32'(pe));
        @(negedge clk);
    endtask

    function automatic outs_t zo();
        outs_t e = '0;
        e.illegal = ill_exp;
        return e;
    endfunction

    function automatic outs_t fe(input logic rdy);
        outs_t e = zo();
        e.mem_req    = 1'b1;
        e.ir_write   = rdy;
        e.pc_write   = rdy;
        e.pc_src_inc = rdy;
        return e;
    endfunction

    function automatic outs_t wb(input logic mtr, input logic lnk);
        outs_t e = zo();
        e.reg_write  = 1'b1;
        e.mem_to_reg = mtr;
        e.link       = lnk;
        e.retire     = 1'b1;
        return e;
    endfunction

    function automatic outs_t ex_imm();
        outs_t e = zo();
        e.alu_src_imm = 1'b1;
        return e;
    endfunction

    function automatic outs_t ex_rtype(input logic s);
        outs_t e = zo();
        e.alu_op   = 2'd3;
        e.setflags = s;
        return e;
    endfunction

    function automatic outs_t memx(input logic wr, input logic rdy);
        outs_t e = zo();
        e.mem_req   = 1'b1;
        e.iord      = 1'b1;
        e.mem_write = wr;
        e.retire    = wr & rdy;
        return e;
    endfunction

    function automatic outs_t brx(input logic [2:0] bop, input logic ret);
        outs_t e = zo();
        e.branch_op = bop;
        e.pc_write  = 1'b1;
        e.retire    = ret;
        return e;
    endfunction

    logic [10:0] br_opc [4] = '{11'b00010100000, 11'b11010110000, 11'b10110101000, 11'b01010100000};
    logic [2:0]  br_bop [4] = '{3'd1, 3'd2, 3'd5, 3'd6};

    initial begin
        #10000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        cycle("reset0", 1'b1, 1'b1, '0);
        cycle("reset1", 1'b1, 1'b0, '0);

        // ADDS with one fetch wait state; mem_ready is held high in non-memory states.
        opcode = 11'b10101011000;
        cycle("adds_fwait", 1'b0, 1'b0, fe(1'b0));
        cycle("adds_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("adds_dec",   1'b0, 1'b1, zo());
        cycle("adds_exec",  1'b0, 1'b1, ex_rtype(1'b1));
        cycle("adds_wb",    1'b0, 1'b1, wb(1'b0, 1'b0));

        opcode = 11'b10001011000;
        cycle("add_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("add_dec",   1'b0, 1'b0, zo());
        cycle("add_exec",  1'b0, 1'b0, ex_rtype(1'b0));
        cycle("add_wb",    1'b0, 1'b0, wb(1'b0, 1'b0));

        opcode = 11'b11101011000;
        cycle("subs_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("subs_dec",   1'b0, 1'b1, zo());
        cycle("subs_exec",  1'b0, 1'b1, ex_rtype(1'b1));
        cycle("subs_wb",    1'b0, 1'b1, wb(1'b0, 1'b0));

        opcode = 11'b10010001001;
        cycle("addi_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("addi_dec",   1'b0, 1'b1, zo());
        cycle("addi_exec",  1'b0, 1'b1, ex_imm());
        cycle("addi_wb",    1'b0, 1'b1, wb(1'b0, 1'b0));

        // LDUR with two memory wait states: 7 cycles total.
        opcode = 11'b11111000010;
        cycle("ldur_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("ldur_dec",   1'b0, 1'b1, zo());
        cycle("ldur_exec",  1'b0, 1'b1, ex_imm());
        cycle("ldur_mem0",  1'b0, 1'b0, memx(1'b0, 1'b0));
        cycle("ldur_mem1",  1'b0, 1'b0, memx(1'b0, 1'b0));
        cycle("ldur_mem2",  1'b0, 1'b1, memx(1'b0, 1'b1));
        cycle("ldur_wb",    1'b0, 1'b1, wb(1'b1, 1'b0));

        opcode = 11'b11111000000;
        cycle("stur_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("stur_dec",   1'b0, 1'b1, zo());
        cycle("stur_exec",  1'b0, 1'b1, ex_imm());
        cycle("stur_mem",   1'b0, 1'b1, memx(1'b1, 1'b1));

        opcode = 11'b10110100000;
        cycle("cbz_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("cbz_dec",   1'b0, 1'b1, zo());
        cycle("cbz_exec",  1'b0, 1'b1, brx(3'd4, 1'b1));

        for (int i = 0; i < 4; i++) begin
            opcode = br_opc[i];
            cycle("br_fetch", 1'b0, 1'b1, fe(1'b1));
            cycle("br_dec",   1'b0, 1'b1, zo());
            cycle("br_exec",  1'b0, 1'b1, brx(br_bop[i], 1'b1));
        end

        opcode = 11'b10010100000;
        cycle("bl_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("bl_dec",   1'b0, 1'b1, zo());
        cycle("bl_exec",  1'b0, 1'b1, brx(3'd3, 1'b0));
        cycle("bl_wb",    1'b0, 1'b1, wb(1'b0, 1'b1));

        opcode = 11'b00000000000;
        cycle("ill_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("ill_dec",   1'b0, 1'b1, zo());
`ifdef LEGV8_ILLEGAL_TRAP_EN
        cycle("ill_exec",  1'b0, 1'b1, zo());
        ill_exp = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle("ill_halt", 1'b0, i[0], zo());
        end
`else
        begin
            outs_t e = zo();
            e.retire = 1'b1;
            cycle("ill_exec", 1'b0, 1'b1, e);
        end
        cycle("ill_next", 1'b0, 1'b0, fe(1'b0));
`endif
        ill_exp = 1'b0;
        cycle("reset2", 1'b1, 1'b1, '0);

        // Reset asserted while a STUR is stalled in MEM aborts straight to FETCH.
        opcode = 11'b11111000000;
        cycle("abort_fetch", 1'b0, 1'b1, fe(1'b1));
        cycle("abort_dec",   1'b0, 1'b1, zo());
        cycle("abort_exec",  1'b0, 1'b1, ex_imm());
        cycle("abort_mem",   1'b0, 1'b0, memx(1'b1, 1'b0));
        cycle("abort_rst",   1'b1, 1'b1, '0);
        cycle("abort_rel",   1'b0, 1'b0, fe(1'b0));
        cycle("abort_refet", 1'b0, 1'b1, fe(1'b1));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
